// File: rtl/savestate_pkg.sv
// Shared types and constants for the mapper savestate bus and its sequencer.
package savestate_pkg;

   localparam int SS_ADR_W  = 10;
   localparam int SS_DATA_W = 64;

   typedef logic [SS_ADR_W-1:0]  ss_adr_t;
   typedef logic [SS_DATA_W-1:0] ss_data_t;

   // Register indices on the savestate bus; mapper registers begin at SSREG_INDEX_MAP1.
   localparam ss_adr_t SSREG_INDEX_TOP  = 10'd0;
   localparam ss_adr_t SSREG_INDEX_DMA  = 10'd1;
   localparam ss_adr_t SSREG_INDEX_PPU  = 10'd2;
   localparam ss_adr_t SSREG_INDEX_APU  = 10'd3;
   localparam ss_adr_t SSREG_INDEX_MAP1 = 10'd4;
   localparam ss_adr_t SSREG_INDEX_MAP2 = 10'd5;
   localparam ss_adr_t SSREG_INDEX_MAP3 = 10'd6;
   localparam ss_adr_t SSREG_INDEX_MAP4 = 10'd7;

   typedef enum logic [3:0] {
      IDLE,
      PAUSE,
      S_ADR,
      S_CAP,
      S_WR,
      L_RD,
      L_WR,
      CLR,
      APPLY,
      FIN
   } state_e;

   typedef enum logic [1:0] {
      SAVE,
      LOAD,
      CLEAR
   } cmd_e;

endpackage

// File: rtl/mapper_savestate_seq.sv
// Halts the core and walks the mapper savestate registers, moving each image
// to or from savestate memory over a req/ack port.
module mapper_savestate_seq
   import savestate_pkg::*;
#(
   parameter int REG_FIRST = 0,
   parameter int REG_COUNT = 8,
   parameter int MEM_AW    = 12,
   parameter int MEM_BASE  = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start_save,
   input  logic                 start_load,
   input  logic                 start_clear,
   output logic                 busy,
   output logic                 done,
   output logic                 cpu_pause,
   input  logic                 cpu_paused,
   output logic [SS_DATA_W-1:0] ss_din,
   output logic [SS_ADR_W-1:0]  ss_adr,
   output logic                 ss_wren,
   output logic                 ss_rst,
   output logic                 ss_load,
   input  logic [SS_DATA_W-1:0] ss_dout,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [MEM_AW-1:0]    mem_addr,
   output logic [SS_DATA_W-1:0] mem_wdata,
   input  logic                 mem_ack,
   input  logic [SS_DATA_W-1:0] mem_rdata
);

   localparam int               IDX_W    = $clog2(REG_COUNT + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(REG_COUNT - 1);

   state_e                 state_q, state_d;
   cmd_e                   cmd_q, cmd_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic                   pause_armed_q, pause_armed_d;
   logic [SS_ADR_W-1:0]    ss_adr_q, ss_adr_d;
   logic [MEM_AW-1:0]      mem_addr_q, mem_addr_d;
   logic [SS_DATA_W-1:0]   ss_din_q, ss_din_d;
   logic [SS_DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

   logic [SS_ADR_W-1:0]    cur_ss_adr;
   logic [MEM_AW-1:0]      cur_mem_addr;
   logic                   is_last;

   assign cur_ss_adr   = SS_ADR_W'(REG_FIRST) + SS_ADR_W'(idx_q);
   assign cur_mem_addr = MEM_AW'(MEM_BASE) + MEM_AW'(idx_q);
   assign is_last      = (idx_q == IDX_LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values; the datapath holds are reset too since every output must read 0.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         cmd_q         <= SAVE;
         idx_q         <= '0;
         pause_armed_q <= 1'b0;
         ss_adr_q      <= '0;
         mem_addr_q    <= '0;
         ss_din_q      <= '0;
         mem_wdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         cmd_q         <= cmd_d;
         idx_q         <= idx_d;
         pause_armed_q <= pause_armed_d;
         ss_adr_q      <= ss_adr_d;
         mem_addr_q    <= mem_addr_d;
         ss_din_q      <= ss_din_d;
         mem_wdata_q   <= mem_wdata_d;
      end
   end

   // NOTE: every signal gets a default before the case so no path infers a latch.
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      idx_d       = idx_q;
      ss_din_d    = ss_din_q;
      mem_wdata_d = mem_wdata_q;

      unique case (state_q)
         IDLE: begin
            if (start_clear || start_load || start_save) begin
               cmd_d   = start_clear ? CLEAR : (start_load ? LOAD : SAVE);
               idx_d   = '0;
               state_d = PAUSE;
            end
         end
         PAUSE: begin
            // A cpu_paused left over from an earlier halt is only trusted once
            // our own request has been visible for a full cycle.
            if (cpu_paused && pause_armed_q) begin
               unique case (cmd_q)
                  SAVE:    state_d = S_ADR;
                  LOAD:    state_d = L_RD;
                  default: state_d = CLR;
               endcase
            end
         end
         S_ADR: state_d = S_CAP;
         S_CAP: begin
            mem_wdata_d = ss_dout;
            state_d     = S_WR;
         end
         S_WR: begin
            if (mem_ack) begin
               if (is_last) begin
                  state_d = FIN;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = S_ADR;
               end
            end
         end
         L_RD: begin
            if (mem_ack) begin
               ss_din_d = mem_rdata;
               state_d  = L_WR;
            end
         end
         L_WR: begin
            if (is_last) begin
               state_d = APPLY;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = L_RD;
            end
         end
         CLR:     state_d = APPLY;
         APPLY:   state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus and memory addresses follow the index while in use and hold otherwise.
   always_comb begin
      pause_armed_d = (state_q == PAUSE);
      ss_adr_d      = ss_adr_q;
      mem_addr_d    = mem_addr_q;
      if (state_q inside {S_ADR, S_CAP, L_WR}) ss_adr_d = cur_ss_adr;
      if (state_q inside {S_WR, L_RD})         mem_addr_d = cur_mem_addr;
   end

   always_comb begin
      busy      = (state_q != IDLE);
      cpu_pause = (state_q != IDLE);
      done      = (state_q == FIN);
      ss_wren   = (state_q == L_WR);
      ss_rst    = (state_q == CLR);
      ss_load   = (state_q == APPLY);
      mem_req   = (state_q == S_WR) || (state_q == L_RD);
      mem_we    = (state_q == S_WR);
      ss_adr    = ss_adr_d;
      mem_addr  = mem_addr_d;
      ss_din    = ss_din_q;
      mem_wdata = mem_wdata_q;
   end

endmodule

// File: tb/tb_mapper_savestate_seq.sv
// Scoreboard bench for mapper_savestate_seq with mapper, core and memory models.
module tb_mapper_savestate_seq;

   localparam int REG_FIRST = 4;
   localparam int REG_COUNT = 3;
   localparam int MEM_AW    = 12;
   localparam int MEM_BASE  = 0;

   typedef struct {
      logic [MEM_AW-1:0] addr;
      logic [63:0]       data;
   } memw_t;

   typedef struct {
      logic [9:0]  adr;
      logic [63:0] din;
      int          cyc;
   } wren_t;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start_save, start_load, start_clear;
   logic              busy, done, cpu_pause;
   logic              cpu_paused;
   logic [63:0]       ss_din;
   logic [9:0]        ss_adr;
   logic              ss_wren, ss_rst, ss_load;
   logic [63:0]       ss_dout;
   logic              mem_req, mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [63:0]       mem_wdata;
   logic              mem_ack;
   logic [63:0]       mem_rdata;

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;
   int st_cyc     = 0;

   int   ack_delay = 0;
   int   wait_cnt  = 0;
   logic force_ack = 1'b0;
   logic hold_core = 1'b0;
   logic [63:0] mem [0:(1<<MEM_AW)-1];

   memw_t exp_memw[$], obs_memw[$];
   wren_t exp_wren[$], obs_wren[$];
   int    obs_done[$], obs_rst[$], obs_load[$];
   logic  obs_done_pause[$];
   int    req_cycles = 0;
   int    overlap_cnt = 0;
   int    pause_late_cnt = 0;
   logic  prev_done = 1'b0;

   mapper_savestate_seq #(
      .REG_FIRST (REG_FIRST),
      .REG_COUNT (REG_COUNT),
      .MEM_AW    (MEM_AW),
      .MEM_BASE  (MEM_BASE)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start_save  (start_save),
      .start_load  (start_load),
      .start_clear (start_clear),
      .busy        (busy),
      .done        (done),
      .cpu_pause   (cpu_pause),
      .cpu_paused  (cpu_paused),
      .ss_din      (ss_din),
      .ss_adr      (ss_adr),
      .ss_wren     (ss_wren),
      .ss_rst      (ss_rst),
      .ss_load     (ss_load),
      .ss_dout     (ss_dout),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Mappers answer one cycle after the address changes.
   always @(posedge clk) ss_dout <= 64'hA0 + {54'd0, ss_adr};

   // Core halts one cycle after being asked, unless held off.
   always @(posedge clk) begin
      if (!reset_n) cpu_paused <= 1'b0;
      else          cpu_paused <= cpu_pause && !hold_core;
   end

   // Memory: ack after ack_delay cycles of request (0 = same cycle).
   always @(posedge clk) begin
      if (!mem_req || mem_ack) wait_cnt <= 0;
      else                     wait_cnt <= wait_cnt + 1;
   end
   assign mem_ack   = force_ack || (mem_req && (wait_cnt >= ack_delay));
   assign mem_rdata = mem[mem_addr];

   always @(negedge clk) begin
      if (reset_n) begin
         if (mem_req && mem_ack && mem_we) begin
            obs_memw.push_back('{mem_addr, mem_wdata});
            mem[mem_addr] = mem_wdata;
         end
         if (ss_wren) obs_wren.push_back('{ss_adr, ss_din, cyc});
         if (ss_rst)  obs_rst.push_back(cyc);
         if (ss_load) obs_load.push_back(cyc);
         if (done) begin
            obs_done.push_back(cyc);
            obs_done_pause.push_back(cpu_pause);
         end
         if (mem_req) req_cycles++;
         if (prev_done && cpu_pause) pause_late_cnt++;
         if ((int'(ss_wren) + int'(ss_rst) + int'(ss_load)) > 1) overlap_cnt++;
         prev_done = done;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic clear_obs();
      exp_memw.delete(); obs_memw.delete();
      exp_wren.delete(); obs_wren.delete();
      obs_done.delete(); obs_rst.delete(); obs_load.delete();
      obs_done_pause.delete();
      req_cycles = 0;
   endtask

   // Drives a one-cycle start pulse; called and returns at a falling edge.
   task automatic pulse(input logic s, input logic l, input logic c);
      start_save  = s;
      start_load  = l;
      start_clear = c;
      st_cyc      = cyc;
      @(negedge clk);
      start_save  = 1'b0;
      start_load  = 1'b0;
      start_clear = 1'b0;
   endtask

   task automatic push_save_expect();
      for (int i = 0; i < REG_COUNT; i++)
         exp_memw.push_back('{MEM_AW'(MEM_BASE + i), 64'hA0 + 64'(REG_FIRST + i)});
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({busy, done, cpu_pause, ss_wren, ss_rst, ss_load, mem_req, mem_we,
           ss_adr, mem_addr, ss_din, mem_wdata} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: busy=%b pause=%b req=%b adr=%0h got nonzero, expected all 0",
                  busy, cpu_pause, mem_req, ss_adr);
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle: busy=%b expected 0", busy);
      end
   endtask

   task automatic test_save();
      memw_t e, o;
      clear_obs();
      ack_delay = 0;
      push_save_expect();
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL save_busy_before: busy=%b expected 0", busy);
      end
      pulse(1'b1, 1'b0, 1'b0);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL save_busy_rise: busy=%b expected 1", busy);
      end
      repeat (40) @(negedge clk);
      vectors++;
      if (obs_memw.size() != exp_memw.size()) begin
         miscompares++;
         $display("FAIL save_write_count: got %0d expected %0d", obs_memw.size(), exp_memw.size());
      end
      while (exp_memw.size() > 0 && obs_memw.size() > 0) begin
         e = exp_memw.pop_front();
         o = obs_memw.pop_front();
         vectors++;
         if ({o.addr, o.data} !== {e.addr, e.data}) begin
            miscompares++;
            $display("FAIL save_write: got addr %0h data %0h expected addr %0h data %0h",
                     o.addr, o.data, e.addr, e.data);
         end
      end
      vectors++;
      if (obs_done.size() != 1 || obs_done[0] - st_cyc != 12) begin
         miscompares++;
         $display("FAIL save_latency: got %0d done(s), latency %0d expected 1 done at 12",
                  obs_done.size(), (obs_done.size() > 0) ? obs_done[0] - st_cyc : -1);
      end
      vectors++;
      if (obs_done_pause.size() != 1 || obs_done_pause[0] !== 1'b1 || pause_late_cnt != 0) begin
         miscompares++;
         $display("FAIL save_pause_release: late=%0d expected pause high at done and low after",
                  pause_late_cnt);
      end
   endtask

   task automatic test_load();
      wren_t e, o;
      int    last_wren;
      clear_obs();
      mem[MEM_BASE + 0] = 64'h11;
      mem[MEM_BASE + 1] = 64'h22;
      mem[MEM_BASE + 2] = 64'h33;
      ack_delay = 3;
      exp_wren.push_back('{10'(REG_FIRST + 0), 64'h11, 0});
      exp_wren.push_back('{10'(REG_FIRST + 1), 64'h22, 0});
      exp_wren.push_back('{10'(REG_FIRST + 2), 64'h33, 0});
      pulse(1'b0, 1'b1, 1'b0);
      repeat (60) @(negedge clk);
      last_wren = (obs_wren.size() > 0) ? obs_wren[obs_wren.size()-1].cyc : -100;
      vectors++;
      if (obs_wren.size() != exp_wren.size()) begin
         miscompares++;
         $display("FAIL load_wren_count: got %0d expected %0d", obs_wren.size(), exp_wren.size());
      end
      while (exp_wren.size() > 0 && obs_wren.size() > 0) begin
         e = exp_wren.pop_front();
         o = obs_wren.pop_front();
         vectors++;
         if ({o.adr, o.din} !== {e.adr, e.din}) begin
            miscompares++;
            $display("FAIL load_wren: got adr %0h din %0h expected adr %0h din %0h",
                     o.adr, o.din, e.adr, e.din);
         end
      end
      vectors++;
      if (obs_load.size() != 1 || obs_load[0] != last_wren + 1) begin
         miscompares++;
         $display("FAIL load_apply: got %0d ss_load pulse(s) at %0d expected 1 at %0d",
                  obs_load.size(), (obs_load.size() > 0) ? obs_load[0] : -1, last_wren + 1);
      end
      vectors++;
      if (obs_memw.size() != 0 || obs_done.size() != 1) begin
         miscompares++;
         $display("FAIL load_no_write: got %0d writes %0d done(s) expected 0 and 1",
                  obs_memw.size(), obs_done.size());
      end
   endtask

   task automatic test_priority();
      wren_t o;
      clear_obs();
      ack_delay = 0;
      pulse(1'b1, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      pulse(1'b0, 1'b0, 1'b1);
      repeat (40) @(negedge clk);
      vectors++;
      if (obs_memw.size() != 0 || obs_wren.size() != 3) begin
         miscompares++;
         $display("FAIL prio_load_wins: got %0d writes %0d wrens expected 0 and 3",
                  obs_memw.size(), obs_wren.size());
      end
      if (obs_wren.size() == 3) begin
         o = obs_wren[2];
         vectors++;
         if ({o.adr, o.din} !== {10'(REG_FIRST + 2), 64'h33}) begin
            miscompares++;
            $display("FAIL prio_last_wren: got adr %0h din %0h expected adr %0h din 33",
                     o.adr, o.din, REG_FIRST + 2);
         end
      end
      vectors++;
      if (obs_rst.size() != 0) begin
         miscompares++;
         $display("FAIL busy_clear_ignored: got %0d ss_rst pulse(s) expected 0", obs_rst.size());
      end
      vectors++;
      if (obs_done.size() != 1 || obs_done[0] - (st_cyc - 3) != 10) begin
         miscompares++;
         $display("FAIL load_latency: got %0d done(s), latency %0d expected 1 done at 10",
                  obs_done.size(), (obs_done.size() > 0) ? obs_done[0] - (st_cyc - 3) : -1);
      end
   endtask

   task automatic test_clear();
      clear_obs();
      pulse(1'b0, 1'b0, 1'b1);
      repeat (20) @(negedge clk);
      vectors++;
      if (obs_rst.size() != 1 || obs_load.size() != 1 || obs_load[0] != obs_rst[0] + 1) begin
         miscompares++;
         $display("FAIL clear_sequence: got %0d ss_rst %0d ss_load expected 1 each, adjacent",
                  obs_rst.size(), obs_load.size());
      end
      vectors++;
      if (obs_done.size() != 1 || obs_done[0] - st_cyc != 5) begin
         miscompares++;
         $display("FAIL clear_latency: got %0d done(s), latency %0d expected 1 done at 5",
                  obs_done.size(), (obs_done.size() > 0) ? obs_done[0] - st_cyc : -1);
      end
      vectors++;
      if (req_cycles != 0) begin
         miscompares++;
         $display("FAIL clear_no_mem: got %0d mem_req cycles expected 0", req_cycles);
      end
   endtask

   task automatic test_back_to_back();
      int k;
      clear_obs();
      pulse(1'b0, 1'b0, 1'b1);
      k = 0;
      while (done !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_first_done: done=%b after %0d cycles expected 1", done, k);
      end
      @(negedge clk);
      pulse(1'b1, 1'b0, 1'b0);
      repeat (30) @(negedge clk);
      vectors++;
      if (obs_done.size() != 2 || obs_done[1] - obs_done[0] != 13 || obs_memw.size() != 3) begin
         miscompares++;
         $display("FAIL b2b_accept: got %0d done(s) %0d writes, gap %0d expected 2, 3, 13",
                  obs_done.size(), obs_memw.size(),
                  (obs_done.size() > 1) ? obs_done[1] - obs_done[0] : -1);
      end
      vectors++;
      if (overlap_cnt != 0) begin
         miscompares++;
         $display("FAIL strobe_overlap: got %0d overlapping cycles expected 0", overlap_cnt);
      end
   endtask

   task automatic test_pause_hold();
      memw_t e, o;
      clear_obs();
      ack_delay = 0;
      hold_core = 1'b1;
      force_ack = 1'b1;
      push_save_expect();
      pulse(1'b1, 1'b0, 1'b0);
      repeat (50) @(negedge clk);
      vectors++;
      if (req_cycles != 0 || obs_wren.size() != 0 || obs_memw.size() != 0 ||
          ss_adr !== 10'(REG_FIRST + 2) || mem_addr !== MEM_AW'(MEM_BASE + 2)) begin
         miscompares++;
         $display("FAIL pause_quiet: got req=%0d adr=%0h maddr=%0h expected 0, %0h, %0h",
                  req_cycles, ss_adr, mem_addr, REG_FIRST + 2, MEM_BASE + 2);
      end
      vectors++;
      if (busy !== 1'b1 || cpu_pause !== 1'b1) begin
         miscompares++;
         $display("FAIL pause_waiting: busy=%b pause=%b expected 1 1", busy, cpu_pause);
      end
      force_ack = 1'b0;
      hold_core = 1'b0;
      repeat (30) @(negedge clk);
      vectors++;
      if (obs_memw.size() != exp_memw.size() || obs_done.size() != 1) begin
         miscompares++;
         $display("FAIL pause_resume: got %0d writes %0d done(s) expected %0d and 1",
                  obs_memw.size(), obs_done.size(), exp_memw.size());
      end
      while (exp_memw.size() > 0 && obs_memw.size() > 0) begin
         e = exp_memw.pop_front();
         o = obs_memw.pop_front();
         vectors++;
         if ({o.addr, o.data} !== {e.addr, e.data}) begin
            miscompares++;
            $display("FAIL pause_write: got addr %0h data %0h expected addr %0h data %0h",
                     o.addr, o.data, e.addr, e.data);
         end
      end
   endtask

   task automatic test_reset_midop();
      memw_t e, o;
      int    k;
      clear_obs();
      ack_delay = 1000;
      pulse(1'b1, 1'b0, 1'b0);
      k = 0;
      while (mem_req !== 1'b1 && k < 30) begin
         @(negedge clk);
         k++;
      end
      vectors++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
         miscompares++;
         $display("FAIL midop_reach_wr: req=%b we=%b expected 1 1", mem_req, mem_we);
      end
      reset_n = 1'b0;
      @(negedge clk);
      vectors++;
      if ({busy, done, cpu_pause, ss_wren, ss_rst, ss_load, mem_req, mem_we,
           ss_adr, mem_addr, ss_din, mem_wdata} !== '0) begin
         miscompares++;
         $display("FAIL midop_reset: busy=%b pause=%b req=%b adr=%0h got nonzero, expected all 0",
                  busy, cpu_pause, mem_req, ss_adr);
      end
      reset_n = 1'b1;
      ack_delay = 0;
      @(negedge clk);
      vectors++;
      if (obs_done.size() != 0 || obs_memw.size() != 0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL midop_abort: got %0d done(s) %0d writes busy=%b expected 0 0 0",
                  obs_done.size(), obs_memw.size(), busy);
      end
      clear_obs();
      push_save_expect();
      pulse(1'b1, 1'b0, 1'b0);
      repeat (30) @(negedge clk);
      vectors++;
      if (obs_done.size() != 1 || obs_done[0] - st_cyc != 12) begin
         miscompares++;
         $display("FAIL midop_resave: got %0d done(s), latency %0d expected 1 at 12",
                  obs_done.size(), (obs_done.size() > 0) ? obs_done[0] - st_cyc : -1);
      end
      while (exp_memw.size() > 0 && obs_memw.size() > 0) begin
         e = exp_memw.pop_front();
         o = obs_memw.pop_front();
         vectors++;
         if ({o.addr, o.data} !== {e.addr, e.data}) begin
            miscompares++;
            $display("FAIL midop_write: got addr %0h data %0h expected addr %0h data %0h",
                     o.addr, o.data, e.addr, e.data);
         end
      end
   endtask

   initial begin
      reset_n     = 1'b0;
      start_save  = 1'b0;
      start_load  = 1'b0;
      start_clear = 1'b0;
      for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = 64'd0;
      @(negedge clk);
      test_reset();
      test_save();
      test_load();
      test_priority();
      test_clear();
      test_back_to_back();
      test_pause_hold();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mapper_savestate_seq.md
# mapper_savestate_seq

Sequencer for the mapper savestate bus. On a save, load or clear command it halts the NES core. It then walks the mapper-register index range on `SaveStateBus_*`, moving each 64-bit register image to or from savestate memory over a req/ack port, and releases the core when finished. It sits between the savestate controller and the shared mapper savestate bus, so individual mappers never see memory timing.

## Interface
Parameters:
- `REG_FIRST`, default 0: first savestate register index driven on `ss_adr`.
- `REG_COUNT`, default 8: number of consecutive indices handled (1..1023).
- `MEM_AW`, default 12: savestate memory word-address width.
- `MEM_BASE`, default 0: memory word address of register `REG_FIRST`.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `start_save` in 1: one-cycle command pulse.
- `start_load` in 1: one-cycle command pulse.
- `start_clear` in 1: one-cycle command pulse.
- `busy` out 1: high from command acceptance until `done`.
- `done` out 1: one-cycle pulse when a command completes.
- `cpu_pause` out 1: core halt request.
- `cpu_paused` in 1: core has halted.
- `ss_din` out 64: register image to the mappers.
- `ss_adr` out 10: register index.
- `ss_wren` out 1: register image write strobe.
- `ss_rst` out 1: reset mapper registers to their defaults.
- `ss_load` out 1: mappers copy the loaded images into live state.
- `ss_dout` in 64: OR of the mapper `SaveStateBus_Dout` outputs.
- `mem_req` out 1: memory request.
- `mem_we` out 1: memory write enable.
- `mem_addr` out MEM_AW: memory word address.
- `mem_wdata` out 64: memory write data.
- `mem_ack` in 1: memory acknowledge.
- `mem_rdata` in 64: memory read data, valid with `mem_ack`.

## Operation
- Reset value of every output is 0. State returns to IDLE.
- Reset mid-operation aborts the command immediately:
  - `cpu_pause` drops.
  - No `done` is issued.
  - Partially written memory or registers are left as they are.
- States: IDLE, PAUSE, S_ADR, S_CAP, S_WR, L_RD, L_WR, CLR, APPLY, FIN.
- IDLE:
  - Accepts a command only here. Starts arriving while `busy` are ignored.
  - Simultaneous starts are prioritised clear > load > save.
  - On acceptance: latch the command, set index `i`=0, go to PAUSE.
- PAUSE:
  - Assert `cpu_pause`; it stays high through FIN.
  - Wait for `cpu_paused`=1.
  - Then save goes to S_ADR, load goes to L_RD, clear goes to CLR.
- Save path:
  - S_ADR: drive `ss_adr`=REG_FIRST+i.
  - S_CAP: hold the address and register `ss_dout` into `mem_wdata`.
  - S_WR: hold `mem_req`=1, `mem_we`=1, `mem_addr`=MEM_BASE+i until `mem_ack`.
  - On ack: if i=REG_COUNT-1 go to FIN, else i+1 and go to S_ADR.
- Load path:
  - L_RD: hold `mem_req`=1, `mem_we`=0, `mem_addr`=MEM_BASE+i until `mem_ack`. Capture `mem_rdata` into `ss_din` on ack.
  - L_WR: `ss_wren`=1 for exactly one cycle with `ss_adr`=REG_FIRST+i.
  - Then if last go to APPLY, else i+1 and go to L_RD.
- Clear path:
  - CLR: `ss_rst`=1 for one cycle, then go to APPLY.
- APPLY: `ss_load`=1 for one cycle, then go to FIN.
- FIN: `done`=1 for one cycle, `cpu_pause` drops, go to IDLE.
- Address arithmetic:
  - `ss_adr` is 10 bits; REG_FIRST+i wraps modulo 1024.
  - `mem_addr` is MEM_AW bits; MEM_BASE+i wraps modulo 2^MEM_AW.
  - The index counter is sized ceil(log2(REG_COUNT+1)) bits.
- Outside the states above, `ss_adr`, `ss_din`, `mem_addr` and `mem_wdata` hold their last value. The strobes are 0.

## Timing
- Memory handshake:
  - `mem_req` stays high until sampled with `mem_ack`=1 and drops the following cycle.
  - An ack in the same cycle `mem_req` first rises is legal.
  - `mem_ack` while `mem_req`=0 is ignored.
- `ss_dout` is valid one cycle after `ss_adr` changes; S_CAP samples it exactly one cycle after S_ADR.
- `ss_wren`, `ss_rst` and `ss_load` never overlap.
- Latency with zero-wait ack and an immediate `cpu_paused`, measured from the start pulse to `done`:
  - Save: 2 + 3·REG_COUNT + 1 cycles.
  - Load: 2 + 2·REG_COUNT + 2 cycles.
  - Clear: 5 cycles.
- `busy` rises the cycle after the accepted start and falls with `done`.
- A new command is accepted one cycle after `done`.

## Structure
- Shared package `savestate_pkg` holds:
  - the state enum;
  - the command enum (SAVE, LOAD, CLEAR);
  - `SS_ADR_W`=10 and `SS_DATA_W`=64;
  - the mapper register index constants, including `SSREG_INDEX_MAP1`.
- A single module with no sub-modules. The req/ack port is simple enough to remain inline.

## Test plan
- Save, REG_FIRST=4, REG_COUNT=3, mappers return 64'hA0+adr, zero-wait ack -> memory writes at 0,1,2 of A4, A5, A6. `done` arrives 12 cycles after start. `cpu_pause` falls with `done`.
- Load, memory[0..2]=11,22,33, ack delayed 3 cycles each -> `ss_wren` pulses with (adr,din) = (4,11), (5,22), (6,33). One `ss_load` follows the last `ss_wren` by one cycle.
- Clear -> one `ss_rst` cycle, `ss_load` on the next cycle, then `done`. No `mem_req` at any time.
- `start_save` and `start_load` in the same cycle -> a load is performed. A `start_clear` issued while busy is ignored, with no extra `ss_rst`.
- `cpu_paused` held low 50 cycles -> no bus or memory activity until it rises. Sequence then proceeds normally.
- `reset_n` low during S_WR with the ack pending -> next cycle all outputs 0 and state IDLE. A subsequent save completes normally.
